// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU-control encodings plus the M-extension sequencer states and decode helpers.
package muldiv_sequencer_pkg;

  localparam logic [4:0] ALUCTRL_ADD    = 5'b00000;
  localparam logic [4:0] ALUCTRL_SUB    = 5'b00001;
  localparam logic [4:0] ALUCTRL_MUL    = 5'b10000;
  localparam logic [4:0] ALUCTRL_MULH   = 5'b10001;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'b10010;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'b10011;
  localparam logic [4:0] ALUCTRL_DIV    = 5'b10100;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'b10101;
  localparam logic [4:0] ALUCTRL_REM    = 5'b10110;
  localparam logic [4:0] ALUCTRL_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    MDS_IDLE,
    MDS_CALC,
    MDS_FIX,
    MDS_DONE
  } md_state_e;

  function automatic logic is_md(input logic [4:0] code);
    return code inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
                        ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
  endfunction

  function automatic logic md_is_div(input logic [4:0] code);
    return code inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
  endfunction

  function automatic logic md_a_signed(input logic [4:0] code);
    return code inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_DIV, ALUCTRL_REM};
  endfunction

  function automatic logic md_b_signed(input logic [4:0] code);
    return code inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM};
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider on operand magnitudes, with sign fix-up
// and the result register. Sequencing (load/step/fix) comes from muldiv_sequencer.
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  logic [4:0]      op_i,
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  output logic            special_o,
  output logic [BITS-1:0] result_o
);

  localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};

  logic [4:0]      op_q;
  logic            neg_q;
  logic            rem_neg_q;
  logic [BITS-1:0] opnd_q;
  logic [BITS-1:0] lo_q;
  logic [BITS:0]   acc_q;
  logic [BITS-1:0] result_q;

  logic            a_neg, b_neg, div_req, b_zero, ovf;
  logic [BITS-1:0] mag_a, mag_b, special_val;

  always_comb begin
    a_neg       = md_a_signed(op_i) & a_i[BITS-1];
    b_neg       = md_b_signed(op_i) & b_i[BITS-1];
    mag_a       = a_neg ? -a_i : a_i;
    mag_b       = b_neg ? -b_i : b_i;
    div_req     = md_is_div(op_i);
    b_zero      = (b_i == '0);
    ovf         = ((op_i == ALUCTRL_DIV) || (op_i == ALUCTRL_REM)) && (a_i == MIN_NEG) && (b_i == '1);
    special_o   = div_req & (b_zero | ovf);
    special_val = '0;
    if (b_zero) begin
      special_val = ((op_i == ALUCTRL_DIV) || (op_i == ALUCTRL_DIVU)) ? '1 : a_i;
    end else if (op_i == ALUCTRL_DIV) begin
      special_val = a_i;
    end
  end

  // Multiply: acc holds the product high half (bit BITS is the adder carry), lo the multiplier.
  // Divide: acc holds the partial remainder, lo shifts dividend out and quotient in.
  logic [BITS-1:0] addend;
  logic [BITS:0]   sum, rem_sh, rem_nx;
  logic            q_bit;

  always_comb begin
    addend = lo_q[0] ? opnd_q : '0;
    sum    = acc_q + {1'b0, addend};
    rem_sh = {acc_q[BITS-1:0], lo_q[BITS-1]};
    q_bit  = (rem_sh >= {1'b0, opnd_q});
    rem_nx = q_bit ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
  end

  logic [2*BITS-1:0] prod, prod_s;
  logic [BITS-1:0]   quo_s, rem_s, fix_val;

  always_comb begin
    prod   = {acc_q[BITS-1:0], lo_q};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_q : lo_q;
    rem_s  = rem_neg_q ? -acc_q[BITS-1:0] : acc_q[BITS-1:0];
    if (md_is_div(op_q)) begin
      fix_val = ((op_q == ALUCTRL_DIV) || (op_q == ALUCTRL_DIVU)) ? quo_s : rem_s;
    end else begin
      fix_val = (op_q == ALUCTRL_MUL) ? prod_s[BITS-1:0] : prod_s[2*BITS-1:BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else if (load_i) begin
      op_q      <= op_i;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      opnd_q    <= div_req ? mag_b : mag_a;
      lo_q      <= div_req ? mag_a : mag_b;
      acc_q     <= '0;
      if (special_o) begin
        result_q <= special_val;
      end
    end else if (step_i) begin
      if (md_is_div(op_q)) begin
        acc_q <= rem_nx;
        lo_q  <= {lo_q[BITS-2:0], q_bit};
      end else begin
        acc_q <= {1'b0, sum[BITS:1]};
        lo_q  <= {sum[0], lo_q[BITS-1:1]};
      end
    end else if (fix_i) begin
      result_q <= fix_val;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM and iteration counter around muldiv_datapath,
// holding the execute stage with stall until the result is ready.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [4:0]      ALUCtrl,
  input  logic [BITS-1:0] rs1_data,
  input  logic [BITS-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [BITS-1:0] result
);

  localparam int unsigned CW = $clog2(BITS);

  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic            result_valid_q;
  logic            accept, special;

  assign accept = (state_q == MDS_IDLE) & req_valid & is_md(ALUCtrl) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= MDS_IDLE;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        MDS_IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (special) begin
              state_q        <= MDS_DONE;
              result_valid_q <= 1'b1;
            end else begin
              state_q <= MDS_CALC;
            end
          end
        end
        MDS_CALC: begin
          if (flush) begin
            state_q <= MDS_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(BITS - 1)) begin
              state_q <= MDS_FIX;
            end
          end
        end
        MDS_FIX: begin
          if (flush) begin
            state_q <= MDS_IDLE;
          end else begin
            state_q        <= MDS_DONE;
            result_valid_q <= 1'b1;
          end
        end
        default: state_q <= MDS_IDLE;
      endcase
    end
  end

  muldiv_datapath #(.BITS(BITS)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .step_i    (state_q == MDS_CALC),
    .fix_i     ((state_q == MDS_FIX) & ~flush),
    .op_i      (ALUCtrl),
    .a_i       (rs1_data),
    .b_i       (rs2_data),
    .special_o (special),
    .result_o  (result)
  );

  assign stall        = ~rst & req_valid & is_md(ALUCtrl) & (state_q != MDS_DONE) & ~flush;
  assign busy         = (state_q != MDS_IDLE);
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a cycle-level reference model checked every cycle.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [4:0]  ALUCtrl = ALUCTRL_ADD;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_c = 0;

  muldiv_sequencer #(.BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .ALUCtrl      (ALUCtrl),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic m_code(input logic [4:0] c);
    return c inside {ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
                     ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
  endfunction

  // Reference result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (op)
      ALUCTRL_MUL:    begin p = sa * sb; return p[31:0];  end
      ALUCTRL_MULH:   begin p = sa * sb; return p[63:32]; end
      ALUCTRL_MULHSU: begin p = sa * ub; return p[63:32]; end
      ALUCTRL_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALUCTRL_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      ALUCTRL_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      ALUCTRL_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      ALUCTRL_REMU:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      default:        return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic dv;
    dv = op inside {ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU};
    if (dv && (b == 0)) return 1;
    if ((op == ALUCTRL_DIV || op == ALUCTRL_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Model: an accepted op occupies cycles acc+1..done, pulses result in done.
  logic        m_in_op = 1'b0;
  int          m_acc = 0, m_done = 0;
  logic [31:0] m_res = '0, m_held = '0;
  logic        m_busy, m_rv, m_stall;

  always @(negedge clk) begin
    if (rst) begin
      m_in_op = 1'b0;
      m_held  = '0;
      chk("rst_busy",   32'(busy),         32'd0);
      chk("rst_stall",  32'(stall),        32'd0);
      chk("rst_valid",  32'(result_valid), 32'd0);
      chk("rst_result", result,            32'd0);
    end else begin
      m_busy  = m_in_op && (cyc > m_acc) && (cyc <= m_done);
      m_rv    = m_busy && (cyc == m_done);
      if (m_rv) m_held = m_res;
      m_stall = req_valid && m_code(ALUCtrl) && !flush && !m_rv;
      chk("busy",   32'(busy),         32'(m_busy));
      chk("valid",  32'(result_valid), 32'(m_rv));
      chk("stall",  32'(stall),        32'(m_stall));
      chk("result", result,            m_held);
      if (m_busy && flush && (cyc < m_done)) begin
        m_in_op = 1'b0;
      end else if (!m_busy && req_valid && m_code(ALUCtrl) && !flush) begin
        m_in_op = 1'b1;
        m_acc   = cyc;
        m_done  = cyc + ref_lat(ALUCtrl, rs1_data, rs2_data);
        m_res   = ref_md(ALUCtrl, rs1_data, rs2_data);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    req_valid = 1'b1;
    ALUCtrl   = op;
    rs1_data  = a;
    rs2_data  = b;
    start_c   = cyc;
  endtask

  task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   n;
    logic got;
    issue(op, a, b);
    @(posedge clk); #1;
    rs1_data = ~a;
    rs2_data = ~b;
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      if (result_valid) got = 1'b1;
      else n++;
    end
    chk({nm, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, "_lat"}, 32'(cyc - start_c), 32'(lat));
      chk({nm, "_res"}, result, exp);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    ALUCtrl   = ALUCTRL_ADD;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk("pin_mul",    ref_md(ALUCTRL_MUL,    32'd7,         32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("pin_mulhsu", ref_md(ALUCTRL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("pin_rem",    ref_md(ALUCTRL_REM,    32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFF);
    chk("pin_divovf", ref_md(ALUCTRL_DIV,    32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op("mul",    ALUCTRL_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh",   ALUCTRL_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu",  ALUCTRL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu", ALUCTRL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("div",    ALUCTRL_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem",    ALUCTRL_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu",   ALUCTRL_DIVU,   32'd100,       32'd7,         32'd14,        34);
    run_op("remu",   ALUCTRL_REMU,   32'd100,       32'd7,         32'd2,         34);
    go_idle();

    run_op("divu0",  ALUCTRL_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem0",   ALUCTRL_REM,    32'd5,         32'd0,         32'd5,         1);
    run_op("divovf", ALUCTRL_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", ALUCTRL_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    go_idle();

    // flush in cycle 10 of a MUL
    issue(ALUCTRL_MUL, 32'd11, 32'd13);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    go_idle();
    @(negedge clk);
    chk("flush_idle", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    run_op("after_flush", ALUCTRL_DIVU, 32'd9, 32'd3, 32'd3, 34);
    go_idle();

    // flush in IDLE suppresses accept
    @(posedge clk); #1;
    req_valid = 1'b1; ALUCtrl = ALUCTRL_MUL; rs1_data = 32'd2; rs2_data = 32'd2; flush = 1'b1;
    go_idle();
    @(negedge clk);
    chk("flush_noaccept", 32'(busy), 32'd0);

    // reset mid-CALC
    issue(ALUCTRL_MUL, 32'd21, 32'd2);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("midrst_busy",   32'(busy), 32'd0);
    chk("midrst_result", result,    32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // back-to-back
    run_op("b2b_a", ALUCTRL_MUL, 32'd3, 32'd4, 32'd12, 34);
    run_op("b2b_b", ALUCTRL_MUL, 32'd5, 32'd6, 32'd30, 34);
    go_idle();

    // non-M op is ignored
    @(posedge clk); #1;
    req_valid = 1'b1; ALUCtrl = ALUCTRL_ADD; rs1_data = 32'd1; rs2_data = 32'd1;
    repeat (4) begin
      @(negedge clk);
      chk("add_stall", 32'(stall), 32'd0);
      chk("add_busy",  32'(busy),  32'd0);
    end
    go_idle();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
